// File: rtl/ext_mem_responder.sv
// ext_mem_responder
//   External byte-memory responder for the accelerator's off-chip master port.
//   Two independent channels answer loads/stores that fall inside the owned
//   window with fixed read/write latencies. Responses are zero outside the
//   completion cycle so they can be OR-ed with other responders.
//
// Ports
//   clock               rising-edge clock
//   reset               synchronous, active-low
//   Mout_oe_ram[1:0]    per-channel read enable
//   Mout_we_ram[1:0]    per-channel write enable
//   Mout_addr_ram[13:0] ch0 addr [6:0], ch1 addr [13:7]
//   Mout_Wdata_ram      ch0 data [7:0], ch1 data [15:8]
//   Mout_data_ram_size  ch0 bit-size [3:0], ch1 bit-size [7:4]
//   ld_en/ld_addr/ld_data  preload write port (absolute address)
//   M_Rdata_ram[15:0]   read data lanes, valid only with M_DataRdy
//   M_DataRdy[1:0]      per-channel completion pulse
//   err_conflict        sticky: oe and we seen together on a channel

// Per-channel IDLE/BUSY sequencer with the held read byte.
//   req_rd/req_wr  qualified (in-window, non-conflicting) request
//   mem_byte       array byte at the request address, sampled on first cycle
//   rdy            completion pulse (combinational from held request + cnt)
//   wr_done        completion of a write: commit at the closing edge
//   rdata          read lane, zero unless completing a read
module ext_mem_chan #(
    parameter int RD_DLY = 2,
    parameter int WR_DLY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_rd,
    input  logic       req_wr,
    input  logic [7:0] mem_byte,
    output logic       rdy,
    output logic       wr_done,
    output logic [7:0] rdata
);
    typedef enum logic { IDLE, BUSY } state_t;

    state_t      state;
    logic        is_wr;
    logic [15:0] cnt;
    logic [7:0]  rd_q;
    logic        req;
    logic        match;
    logic [15:0] last;

    assign req  = req_rd | req_wr;
    assign last = req_wr ? 16'(WR_DLY - 1) : 16'(RD_DLY - 1);
    // In BUSY the request must still be present and of the same type.
    assign match = (state == BUSY) ? (req && (req_wr == is_wr)) : req;
    // Gated by reset so a transaction in flight at reset never completes.
    // In IDLE cnt is 0, which gives the same-cycle pulse for a 1-cycle write.
    assign rdy     = reset && match && (cnt == last);
    assign wr_done = rdy && req_wr;
    assign rdata   = (rdy && req_rd) ? rd_q : 8'h00;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            is_wr <= 1'b0;
            cnt   <= '0;
            rd_q  <= '0;
        end else if (state == BUSY && !match) begin
            state <= IDLE;           // abort: dropped or type changed
            cnt   <= '0;
        end else if (rdy) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (req) begin
            if (state == IDLE) begin
                state <= BUSY;
                is_wr <= req_wr;
                // Nonblocking sample: a commit on this same edge is not seen.
                if (req_rd) rd_q <= mem_byte;
            end
            cnt <= cnt + 16'd1;
        end
    end
endmodule

module ext_mem_responder #(
    parameter int BASE_ADDR   = 0,
    parameter int MEM_BYTES   = 32,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  Mout_oe_ram,
    input  logic [1:0]  Mout_we_ram,
    input  logic [13:0] Mout_addr_ram,
    input  logic [15:0] Mout_Wdata_ram,
    input  logic [7:0]  Mout_data_ram_size,
    input  logic        ld_en,
    input  logic [6:0]  ld_addr,
    input  logic [7:0]  ld_data,
    output logic [15:0] M_Rdata_ram,
    output logic [1:0]  M_DataRdy,
    output logic        err_conflict
);
    localparam int NUM_LANES = 2;
    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    logic [7:0] mem [MEM_BYTES];

    logic [NUM_LANES-1:0][6:0]    addr;
    logic [NUM_LANES-1:0][7:0]    wdata;
    logic [NUM_LANES-1:0][7:0]    mask;
    logic [NUM_LANES-1:0][AW-1:0] idx;
    logic [NUM_LANES-1:0][7:0]    mem_byte;
    logic [NUM_LANES-1:0][7:0]    lane;
    logic [NUM_LANES-1:0]         in_win;
    logic [NUM_LANES-1:0]         req_rd;
    logic [NUM_LANES-1:0]         req_wr;
    logic [NUM_LANES-1:0]         rdy;
    logic [NUM_LANES-1:0]         wr_done;
    logic                         ld_win;
    logic [AW-1:0]                ld_idx;

    function automatic logic in_window(input logic [6:0] a);
        return ({25'd0, a} >= 32'(BASE_ADDR)) &&
               ({25'd0, a} <  32'(BASE_ADDR + MEM_BYTES));
    endfunction

    function automatic logic [AW-1:0] to_idx(input logic [6:0] a);
        return AW'({25'd0, a} - 32'(BASE_ADDR));
    endfunction

    // Bit-size mask; sizes of 8 and above cover the whole byte.
    function automatic logic [7:0] size_mask(input logic [3:0] s);
        return s[3] ? 8'hFF : ((8'd1 << s[2:0]) - 8'd1);
    endfunction

    genvar c;
    generate
        for (c = 0; c < NUM_LANES; c++) begin : g_ch
            assign addr[c]     = Mout_addr_ram[c*7 +: 7];
            assign wdata[c]    = Mout_Wdata_ram[c*8 +: 8];
            assign mask[c]     = size_mask(Mout_data_ram_size[c*4 +: 4]);
            assign in_win[c]   = in_window(addr[c]);
            assign idx[c]      = to_idx(addr[c]);
            assign mem_byte[c] = in_win[c] ? mem[idx[c]] : 8'h00;
            // oe together with we is not a request at all.
            assign req_rd[c]   = in_win[c] && Mout_oe_ram[c] && !Mout_we_ram[c];
            assign req_wr[c]   = in_win[c] && Mout_we_ram[c] && !Mout_oe_ram[c];

            ext_mem_chan #(
                .RD_DLY (READ_DELAY),
                .WR_DLY (WRITE_DELAY)
            ) u_chan (
                .clock    (clock),
                .reset    (reset),
                .req_rd   (req_rd[c]),
                .req_wr   (req_wr[c]),
                .mem_byte (mem_byte[c]),
                .rdy      (rdy[c]),
                .wr_done  (wr_done[c]),
                .rdata    (lane[c])
            );
        end
    endgenerate

    assign ld_win      = in_window(ld_addr);
    assign ld_idx      = to_idx(ld_addr);
    assign M_DataRdy   = rdy;
    assign M_Rdata_ram = lane;

    // Memory is never reset. Later assignments win on a shared address:
    // preload < channel 0 < channel 1.
    always_ff @(posedge clock) begin
        if (ld_en && ld_win) mem[ld_idx] <= ld_data;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_done[i])
                mem[idx[i]] <= (wdata[i] & mask[i]) | (mem[idx[i]] & ~mask[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            err_conflict <= 1'b0;
        else if (|(Mout_oe_ram & Mout_we_ram))
            err_conflict <= 1'b1;
    end
endmodule
